// File: rtl/wb_arb_pkg.sv
// ---------------------------------------------------------------------------
// wb_arb_pkg
// Shared definitions for the two-requester Wishbone arbiter:
//   - arb_state_t      : grant FSM state encoding
//   - TMO_RD_VALUE_DEF : read value handed back when a transfer times out
//   - REQ0 / REQ1      : requester index constants (AHB bridge / engine)
//   - grant_state()    : maps a requester index onto its grant state
// ---------------------------------------------------------------------------
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    TMO    = 2'd3
  } arb_state_t;

  localparam logic [31:0] TMO_RD_VALUE_DEF = 32'hDEFFABAC;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  function automatic arb_state_t grant_state(input logic owner);
    return (owner == REQ1) ? GRANT1 : GRANT0;
  endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// ---------------------------------------------------------------------------
// wb_arb_watchdog
// Loadable saturating down-counter that flags a transfer which has been
// granted for LOAD_VALUE cycles without a slave acknowledge.
//
// Ports:
//   i_clk     in   clock
//   i_rst_n   in   async active-low reset, counter returns to LOAD_VALUE
//   i_load    in   reload the counter with LOAD_VALUE
//   i_enable  in   count down one step (a transfer is running)
//   i_ack     in   slave acknowledge this cycle, suppresses expiry
//   o_expire  out  combinational pulse on the last allowed cycle
// ---------------------------------------------------------------------------
module wb_arb_watchdog #(
  parameter int CNTR_WIDTH = 4,
  parameter int LOAD_VALUE = 15
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_enable,
  input  logic i_ack,
  output logic o_expire
);

  localparam logic [CNTR_WIDTH-1:0] LP_LOAD = CNTR_WIDTH'(LOAD_VALUE);
  localparam logic [CNTR_WIDTH-1:0] LP_ONE  = CNTR_WIDTH'(1);

  logic [CNTR_WIDTH-1:0] r_count;

  // Load has priority over counting; the count stops at zero rather than
  // wrapping so a stuck enable can never re-arm a fresh timeout window.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= LP_LOAD;
    end else if (i_load) begin
      r_count <= LP_LOAD;
    end else if (i_enable && (r_count != '0)) begin
      r_count <= r_count - LP_ONE;
    end
  end

  // A slave acknowledge arriving on the final cycle beats the timeout.
  assign o_expire = i_enable & ~i_ack & (r_count == LP_ONE);

endmodule

// File: rtl/wb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// wb_bus_arbiter
// Round-robin arbiter sharing one Wishbone slave bus between requester 0
// (AHB-to-FPGA bridge) and requester 1 (internal engine). A grant is held
// for one complete transfer; a watchdog turns a transfer that never gets a
// slave ACK into an error acknowledge carrying TMO_RD_VALUE.
//
// Ports:
//   WBs_CLK_i, WBs_RSTn_i        clock, async active-low reset
//   M0_* / M1_* (inputs)         requester address/cycle/strobe/we/bytes/data
//   M0_DAT_o/M0_ACK_o, M1_...    read data and acknowledge per requester
//   WBs_*_o                      steered slave bus
//   WBs_DAT_i, WBs_ACK_i         slave read data and acknowledge
//   Tmo_Err_o, Tmo_Owner_o       sticky timeout flag, requester that timed out
//   Tmo_Clr_i                    clears Tmo_Err_o (a new timeout wins)
// ---------------------------------------------------------------------------
module wb_bus_arbiter
  import wb_arb_pkg::*;
#(
  parameter int                   ADDRWIDTH      = 17,
  parameter int                   DATAWIDTH      = 32,
  parameter int                   TMO_CNTR_WIDTH = 4,
  parameter int                   TMO_CYCLES     = 15,
  parameter logic [DATAWIDTH-1:0] TMO_RD_VALUE   = DATAWIDTH'(TMO_RD_VALUE_DEF)
) (
  input  logic                 WBs_CLK_i,
  input  logic                 WBs_RSTn_i,

  input  logic [ADDRWIDTH-1:0] M0_ADR_i,
  input  logic                 M0_CYC_i,
  input  logic                 M0_STB_i,
  input  logic                 M0_WE_i,
  input  logic [3:0]           M0_BYTE_STB_i,
  input  logic [DATAWIDTH-1:0] M0_DAT_i,
  output logic [DATAWIDTH-1:0] M0_DAT_o,
  output logic                 M0_ACK_o,

  input  logic [ADDRWIDTH-1:0] M1_ADR_i,
  input  logic                 M1_CYC_i,
  input  logic                 M1_STB_i,
  input  logic                 M1_WE_i,
  input  logic [3:0]           M1_BYTE_STB_i,
  input  logic [DATAWIDTH-1:0] M1_DAT_i,
  output logic [DATAWIDTH-1:0] M1_DAT_o,
  output logic                 M1_ACK_o,

  output logic [ADDRWIDTH-1:0] WBs_ADR_o,
  output logic                 WBs_CYC_o,
  output logic                 WBs_STB_o,
  output logic                 WBs_WE_o,
  output logic [3:0]           WBs_BYTE_STB_o,
  output logic [DATAWIDTH-1:0] WBs_DAT_o,
  input  logic [DATAWIDTH-1:0] WBs_DAT_i,
  input  logic                 WBs_ACK_i,

  output logic                 Tmo_Err_o,
  output logic                 Tmo_Owner_o,
  input  logic                 Tmo_Clr_i
);

  arb_state_t r_state;
  arb_state_t w_stateNext;
  logic       r_lastOwner;
  logic       r_tmoErr;
  logic       r_tmoOwner;

  logic       w_req0;
  logic       w_req1;
  logic       w_granted;
  logic       w_owner;
  logic       w_ownerCyc;
  logic       w_ownerStb;
  logic       w_wdLoad;
  logic       w_wdEnable;
  logic       w_wdExpire;
  logic       w_tmoEnter;

  assign w_req0 = M0_CYC_i & M0_STB_i;
  assign w_req1 = M1_CYC_i & M1_STB_i;

  assign w_granted = (r_state == GRANT0) || (r_state == GRANT1);

  // While in TMO the grant state is gone, but r_lastOwner was already
  // updated on the way in, so it names the requester being error-acked.
  assign w_owner    = (r_state == TMO) ? r_lastOwner : (r_state == GRANT1);
  assign w_ownerCyc = (w_owner == REQ1) ? M1_CYC_i : M0_CYC_i;
  assign w_ownerStb = (w_owner == REQ1) ? M1_STB_i : M0_STB_i;

  assign w_tmoEnter = w_granted && (w_stateNext == TMO);

  wb_arb_watchdog #(
    .CNTR_WIDTH (TMO_CNTR_WIDTH),
    .LOAD_VALUE (TMO_CYCLES)
  ) u_watchdog (
    .i_clk    (WBs_CLK_i),
    .i_rst_n  (WBs_RSTn_i),
    .i_load   (w_wdLoad),
    .i_enable (w_wdEnable),
    .i_ack    (WBs_ACK_i),
    .o_expire (w_wdExpire)
  );

  // Grant FSM. IDLE always sits between two grants, which is what lets the
  // other requester in after every transfer. Abort is checked before the
  // slave ACK so a requester that already left never receives one.
  always_comb begin
    w_stateNext = r_state;
    w_wdLoad    = 1'b0;
    w_wdEnable  = 1'b0;
    case (r_state)
      IDLE: begin
        w_wdLoad = 1'b1;
        if (w_req0 && w_req1) begin
          w_stateNext = (r_lastOwner == REQ0) ? GRANT1 : GRANT0;
        end else if (w_req0) begin
          w_stateNext = grant_state(REQ0);
        end else if (w_req1) begin
          w_stateNext = grant_state(REQ1);
        end
      end
      GRANT0, GRANT1: begin
        w_wdEnable = w_ownerCyc;
        if (!w_ownerCyc) begin
          w_stateNext = IDLE;
        end else if (WBs_ACK_i) begin
          w_stateNext = IDLE;
        end else if (w_wdExpire) begin
          w_stateNext = TMO;
        end
      end
      TMO: begin
        w_wdLoad    = 1'b1;
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // State, round-robin memory and the sticky timeout flag. A timeout being
  // raised takes precedence over a simultaneous clear request.
  always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
    if (!WBs_RSTn_i) begin
      r_state     <= IDLE;
      r_lastOwner <= REQ1;
      r_tmoErr    <= 1'b0;
      r_tmoOwner  <= REQ0;
    end else begin
      r_state <= w_stateNext;
      if (w_granted && (w_stateNext != r_state)) begin
        r_lastOwner <= w_owner;
      end
      if (w_tmoEnter) begin
        r_tmoErr   <= 1'b1;
        r_tmoOwner <= w_owner;
      end else if (Tmo_Clr_i) begin
        r_tmoErr <= 1'b0;
      end
    end
  end

  // Steering mux. Everything is decoded from the registered state, so an
  // asynchronous reset drops strobes and acknowledges immediately.
  always_comb begin
    WBs_ADR_o      = '0;
    WBs_CYC_o      = 1'b0;
    WBs_STB_o      = 1'b0;
    WBs_WE_o       = 1'b0;
    WBs_BYTE_STB_o = '0;
    WBs_DAT_o      = '0;
    M0_ACK_o       = 1'b0;
    M1_ACK_o       = 1'b0;
    M0_DAT_o       = '0;
    M1_DAT_o       = '0;
    if (w_granted) begin
      WBs_ADR_o      = (w_owner == REQ1) ? M1_ADR_i      : M0_ADR_i;
      WBs_WE_o       = (w_owner == REQ1) ? M1_WE_i       : M0_WE_i;
      WBs_BYTE_STB_o = (w_owner == REQ1) ? M1_BYTE_STB_i : M0_BYTE_STB_i;
      WBs_DAT_o      = (w_owner == REQ1) ? M1_DAT_i      : M0_DAT_i;
      WBs_CYC_o      = w_ownerCyc;
      WBs_STB_o      = w_ownerCyc & w_ownerStb;
      if (w_owner == REQ1) begin
        M1_ACK_o = w_ownerCyc & WBs_ACK_i;
        M1_DAT_o = WBs_DAT_i;
      end else begin
        M0_ACK_o = w_ownerCyc & WBs_ACK_i;
        M0_DAT_o = WBs_DAT_i;
      end
    end else if (r_state == TMO) begin
      if (w_owner == REQ1) begin
        M1_ACK_o = 1'b1;
        M1_DAT_o = TMO_RD_VALUE;
      end else begin
        M0_ACK_o = 1'b1;
        M0_DAT_o = TMO_RD_VALUE;
      end
    end
  end

  assign Tmo_Err_o   = r_tmoErr;
  assign Tmo_Owner_o = r_tmoOwner;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_bus_arbiter
// Self-checking bench for wb_bus_arbiter: a table of cycle vectors, a few
// hand-written multi-cycle sequences, then randomized traffic compared with
// a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_wb_bus_arbiter;

  localparam int          TMO_CYC = 15;
  localparam logic [31:0] TMO_VAL = 32'hDEFFABAC;
  localparam logic [16:0] ADR0    = 17'h000A0;
  localparam logic [16:0] ADR1    = 17'h101B1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [16:0] m0Adr, m1Adr;
  logic        m0Cyc, m0Stb, m0We, m1Cyc, m1Stb, m1We;
  logic [3:0]  m0Bs, m1Bs;
  logic [31:0] m0Wd, m1Wd;
  logic [31:0] M0_DAT_o, M1_DAT_o;
  logic        M0_ACK_o, M1_ACK_o;
  logic [16:0] WBs_ADR_o;
  logic        WBs_CYC_o, WBs_STB_o, WBs_WE_o;
  logic [3:0]  WBs_BYTE_STB_o;
  logic [31:0] WBs_DAT_o;
  logic [31:0] sDat;
  logic        sAck;
  logic        Tmo_Err_o, Tmo_Owner_o;
  logic        tmoClr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_bus_arbiter dut (
    .WBs_CLK_i      (clk),
    .WBs_RSTn_i     (rst_n),
    .M0_ADR_i       (m0Adr),
    .M0_CYC_i       (m0Cyc),
    .M0_STB_i       (m0Stb),
    .M0_WE_i        (m0We),
    .M0_BYTE_STB_i  (m0Bs),
    .M0_DAT_i       (m0Wd),
    .M0_DAT_o       (M0_DAT_o),
    .M0_ACK_o       (M0_ACK_o),
    .M1_ADR_i       (m1Adr),
    .M1_CYC_i       (m1Cyc),
    .M1_STB_i       (m1Stb),
    .M1_WE_i        (m1We),
    .M1_BYTE_STB_i  (m1Bs),
    .M1_DAT_i       (m1Wd),
    .M1_DAT_o       (M1_DAT_o),
    .M1_ACK_o       (M1_ACK_o),
    .WBs_ADR_o      (WBs_ADR_o),
    .WBs_CYC_o      (WBs_CYC_o),
    .WBs_STB_o      (WBs_STB_o),
    .WBs_WE_o       (WBs_WE_o),
    .WBs_BYTE_STB_o (WBs_BYTE_STB_o),
    .WBs_DAT_o      (WBs_DAT_o),
    .WBs_DAT_i      (sDat),
    .WBs_ACK_i      (sAck),
    .Tmo_Err_o      (Tmo_Err_o),
    .Tmo_Owner_o    (Tmo_Owner_o),
    .Tmo_Clr_i      (tmoClr)
  );

  typedef struct {
    logic        r0;
    logic        r1;
    logic        ack;
    logic [31:0] sdat;
    int          eSel;
    logic        eAck0;
    logic        eAck1;
  } vec_t;

  vec_t vecs [14];

  // Compares one observed value against the bench's own expectation.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives both requesters' cycle/strobe together plus the slave response.
  task automatic applyStimulus(input logic r0, input logic r1, input logic ack, input logic [31:0] sd);
    m0Cyc = r0;
    m0Stb = r0;
    m1Cyc = r1;
    m1Stb = r1;
    sAck  = ack;
    sDat  = sd;
  endtask

  task automatic toNextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    tmoClr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Random-phase state: requester activity and the reference model.
  bit          act [2];
  bit          gotAck [2];
  logic [16:0] rAdr [2];
  logic [31:0] rWd [2];
  logic        rWe [2];
  logic [3:0]  rBs [2];
  int          mOwner;
  int          mGrantStart;
  bit          mTmo;
  int          mLast;
  bit          mErr;
  int          mErrOwner;

  initial begin
    #1ms;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  initial begin
    int stbCount;
    int ackEarly;

    m0Adr = ADR0; m1Adr = ADR1;
    m0We = 1'b0;  m1We = 1'b0;
    m0Bs = 4'hF;  m1Bs = 4'h3;
    m0Wd = 32'h0000_1111; m1Wd = 32'h0000_2222;

    doReset();
    checkOutput("rst_cyc",   32'(WBs_CYC_o), 32'd0);
    checkOutput("rst_stb",   32'(WBs_STB_o), 32'd0);
    checkOutput("rst_adr",   32'(WBs_ADR_o), 32'd0);
    checkOutput("rst_wdat",  WBs_DAT_o, 32'd0);
    checkOutput("rst_ack0",  32'(M0_ACK_o), 32'd0);
    checkOutput("rst_ack1",  32'(M1_ACK_o), 32'd0);
    checkOutput("rst_dat0",  M0_DAT_o, 32'd0);
    checkOutput("rst_dat1",  M1_DAT_o, 32'd0);
    checkOutput("rst_err",   32'(Tmo_Err_o), 32'd0);
    checkOutput("rst_owner", 32'(Tmo_Owner_o), 32'd0);

    // Tie from reset with alternating service, then a lone M0 read.
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,         0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 32'hA000_0001, 1, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 32'hA000_0002, 0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 32'hA000_0003, 2, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 32'h0,         0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 32'hA000_0005, 1, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,         0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 32'hA000_0007, 2, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,         0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'h0,         0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 32'hBAD0_BAD0, 1, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 32'hBAD0_BAD0, 1, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 32'h1234_5678, 1, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0,         0, 1'b0, 1'b0};

    for (int v = 0; v < 14; v++) begin
      toNextCycle();
      applyStimulus(vecs[v].r0, vecs[v].r1, vecs[v].ack, vecs[v].sdat);
      #3;
      checkOutput($sformatf("vec%0d_stb", v), 32'(WBs_STB_o), 32'(vecs[v].eSel != 0));
      if (vecs[v].eSel != 0)
        checkOutput($sformatf("vec%0d_adr", v), 32'(WBs_ADR_o), 32'((vecs[v].eSel == 1) ? ADR0 : ADR1));
      checkOutput($sformatf("vec%0d_ack0", v), 32'(M0_ACK_o), 32'(vecs[v].eAck0));
      checkOutput($sformatf("vec%0d_ack1", v), 32'(M1_ACK_o), 32'(vecs[v].eAck1));
      if (vecs[v].eAck0) checkOutput($sformatf("vec%0d_dat0", v), M0_DAT_o, vecs[v].sdat);
      else if (vecs[v].eSel != 1) checkOutput($sformatf("vec%0d_dat0z", v), M0_DAT_o, 32'd0);
      if (vecs[v].eAck1) checkOutput($sformatf("vec%0d_dat1", v), M1_DAT_o, vecs[v].sdat);
      else if (vecs[v].eSel != 2) checkOutput($sformatf("vec%0d_dat1z", v), M1_DAT_o, 32'd0);
    end

    // M1 write that the slave never answers.
    m1We = 1'b1;
    toNextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    #3;
    checkOutput("tmo_req_stb", 32'(WBs_STB_o), 32'd0);
    stbCount = 0;
    ackEarly = 0;
    for (int k = 0; k < 40; k++) begin
      toNextCycle();
      #3;
      if (!WBs_STB_o) break;
      stbCount++;
      if (M1_ACK_o) ackEarly++;
    end
    checkOutput("tmo_stb_cycles", 32'(stbCount), 32'(TMO_CYC));
    checkOutput("tmo_early_ack",  32'(ackEarly), 32'd0);
    checkOutput("tmo_cyc",        32'(WBs_CYC_o), 32'd0);
    checkOutput("tmo_ack1",       32'(M1_ACK_o), 32'd1);
    checkOutput("tmo_ack0",       32'(M0_ACK_o), 32'd0);
    checkOutput("tmo_dat1",       M1_DAT_o, TMO_VAL);
    checkOutput("tmo_err",        32'(Tmo_Err_o), 32'd1);
    checkOutput("tmo_owner",      32'(Tmo_Owner_o), 32'd1);
    toNextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    m1We = 1'b0;
    #3;
    checkOutput("tmo_ack_once", 32'(M1_ACK_o), 32'd0);
    checkOutput("tmo_err_held", 32'(Tmo_Err_o), 32'd1);
    toNextCycle();
    tmoClr = 1'b1;
    toNextCycle();
    tmoClr = 1'b0;
    #3;
    checkOutput("tmo_clr", 32'(Tmo_Err_o), 32'd0);

    // Slave ACK lands on the last allowed cycle: ACK wins, no timeout.
    toNextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    stbCount = 0;
    for (int i = 1; i <= TMO_CYC; i++) begin
      toNextCycle();
      applyStimulus(1'b1, 1'b0, (i == TMO_CYC), 32'h5A5A_1234);
      #3;
      if (i < TMO_CYC) begin
        if (WBs_STB_o && !M0_ACK_o) stbCount++;
      end
    end
    checkOutput("edge_stb_cycles", 32'(stbCount), 32'(TMO_CYC - 1));
    checkOutput("edge_stb",  32'(WBs_STB_o), 32'd1);
    checkOutput("edge_ack0", 32'(M0_ACK_o), 32'd1);
    checkOutput("edge_dat0", M0_DAT_o, 32'h5A5A_1234);
    toNextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    #3;
    checkOutput("edge_ack0_after", 32'(M0_ACK_o), 32'd0);
    checkOutput("edge_err",        32'(Tmo_Err_o), 32'd0);

    // M0 aborts two cycles into its grant while M1 waits.
    toNextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    toNextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    #3;
    checkOutput("abort_grant0", 32'(WBs_ADR_o), 32'(ADR0));
    toNextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    toNextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    #3;
    checkOutput("abort_ack0", 32'(M0_ACK_o), 32'd0);
    checkOutput("abort_cyc",  32'(WBs_CYC_o), 32'd0);
    toNextCycle();
    #3;
    checkOutput("abort_idle_cyc", 32'(WBs_CYC_o), 32'd0);
    checkOutput("abort_idle_ack", 32'(M0_ACK_o | M1_ACK_o), 32'd0);
    toNextCycle();
    applyStimulus(1'b0, 1'b1, 1'b1, 32'hCAFE_0001);
    #3;
    checkOutput("abort_grant1_cyc", 32'(WBs_CYC_o), 32'd1);
    checkOutput("abort_grant1_adr", 32'(WBs_ADR_o), 32'(ADR1));
    checkOutput("abort_ack1",       32'(M1_ACK_o), 32'd1);
    checkOutput("abort_dat1",       M1_DAT_o, 32'hCAFE_0001);
    toNextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);

    // Asynchronous reset in the middle of a granted transfer.
    toNextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    toNextCycle();
    #3;
    checkOutput("rstmid_pre_stb", 32'(WBs_STB_o), 32'd1);
    #2;
    sAck  = 1'b1;
    rst_n = 1'b0;
    #1;
    checkOutput("rstmid_stb",  32'(WBs_STB_o), 32'd0);
    checkOutput("rstmid_cyc",  32'(WBs_CYC_o), 32'd0);
    checkOutput("rstmid_ack0", 32'(M0_ACK_o), 32'd0);
    checkOutput("rstmid_ack1", 32'(M1_ACK_o), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    toNextCycle();
    #3;
    checkOutput("rstmid_tie_cyc", 32'(WBs_CYC_o), 32'd1);
    checkOutput("rstmid_tie_adr", 32'(WBs_ADR_o), 32'(ADR0));
    toNextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);

    // Randomized traffic against the reference model.
    doReset();
    mOwner = -1; mGrantStart = 0; mTmo = 1'b0; mLast = 1; mErr = 1'b0; mErrOwner = 0;
    for (int i = 0; i < 2; i++) begin act[i] = 1'b0; gotAck[i] = 1'b0; end
    for (int c = 0; c < 1800; c++) begin
      int          ackPct;
      int          owner;
      bit          eCyc;
      bit          eAck [2];
      logic [31:0] eDat [2];
      bit          newTmo;
      bit          rq0, rq1;

      ackPct = ((c / 300) % 3 == 2) ? 0 : 30;
      toNextCycle();
      for (int i = 0; i < 2; i++) begin
        if (act[i] && (gotAck[i] || ($urandom_range(0, 39) == 0))) begin
          act[i] = 1'b0;
        end else if (!act[i] && ($urandom_range(0, 2) == 0)) begin
          act[i]  = 1'b1;
          rAdr[i] = 17'($urandom);
          rWd[i]  = $urandom;
          rWe[i]  = 1'($urandom);
          rBs[i]  = 4'($urandom);
        end
      end
      m0Adr = rAdr[0]; m0Wd = rWd[0]; m0We = rWe[0]; m0Bs = rBs[0];
      m1Adr = rAdr[1]; m1Wd = rWd[1]; m1We = rWe[1]; m1Bs = rBs[1];
      applyStimulus(act[0], act[1], ($urandom_range(0, 99) < ackPct), $urandom);
      tmoClr = ($urandom_range(0, 15) == 0);
      #3;

      // Expected outputs for this cycle from the transaction view.
      owner = mOwner;
      eCyc  = 1'b0;
      for (int i = 0; i < 2; i++) begin eAck[i] = 1'b0; eDat[i] = 32'h0; end
      if (mTmo) begin
        eAck[owner] = 1'b1;
        eDat[owner] = TMO_VAL;
      end else if (owner >= 0) begin
        eCyc        = act[owner];
        eAck[owner] = act[owner] & sAck;
        eDat[owner] = sDat;
      end

      checkOutput("rnd_cyc",   32'(WBs_CYC_o), 32'(eCyc));
      checkOutput("rnd_stb",   32'(WBs_STB_o), 32'(eCyc));
      checkOutput("rnd_ack0",  32'(M0_ACK_o), 32'(eAck[0]));
      checkOutput("rnd_ack1",  32'(M1_ACK_o), 32'(eAck[1]));
      checkOutput("rnd_err",   32'(Tmo_Err_o), 32'(mErr));
      checkOutput("rnd_owner", 32'(Tmo_Owner_o), 32'(mErrOwner));
      if (eCyc) begin
        checkOutput("rnd_adr",  32'(WBs_ADR_o), 32'(rAdr[owner]));
        checkOutput("rnd_we",   32'(WBs_WE_o), 32'(rWe[owner]));
        checkOutput("rnd_bs",   32'(WBs_BYTE_STB_o), 32'(rBs[owner]));
        checkOutput("rnd_wdat", WBs_DAT_o, rWd[owner]);
      end
      if (eAck[0]) checkOutput("rnd_dat0", M0_DAT_o, eDat[0]);
      else if (owner != 0) checkOutput("rnd_dat0z", M0_DAT_o, 32'd0);
      if (eAck[1]) checkOutput("rnd_dat1", M1_DAT_o, eDat[1]);
      else if (owner != 1) checkOutput("rnd_dat1z", M1_DAT_o, 32'd0);

      // Advance the model by one clock edge.
      newTmo = 1'b0;
      if (mTmo) begin
        mTmo   = 1'b0;
        mOwner = -1;
      end else if (mOwner >= 0) begin
        if (!act[mOwner] || sAck) begin
          mLast  = mOwner;
          mOwner = -1;
        end else if (c == mGrantStart + TMO_CYC - 1) begin
          mTmo      = 1'b1;
          mLast     = mOwner;
          mErrOwner = mOwner;
          newTmo    = 1'b1;
        end
      end else begin
        rq0 = act[0];
        rq1 = act[1];
        if (rq0 && rq1) mOwner = (mLast == 0) ? 1 : 0;
        else if (rq0)   mOwner = 0;
        else if (rq1)   mOwner = 1;
        if (mOwner >= 0) mGrantStart = c + 1;
      end
      if (newTmo) mErr = 1'b1;
      else if (tmoClr) mErr = 1'b0;
      for (int i = 0; i < 2; i++) gotAck[i] = eAck[i];
    end

    toNextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    tmoClr = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
